// File: rtl/dispatcher_pkg.sv
// Shared types and sizes for the chromosome evaluation dispatcher.
package dispatcher_pkg;

  localparam int CHROM_WIDTH   = 992;
  localparam int NUM_OUTPUTS   = 8;
  localparam int ERR_WIDTH     = 32;
  localparam int FITNESS_WIDTH = 35;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_START,
    ST_WAIT_DONE,
    ST_ACK,
    ST_SUM,
    ST_RESULT
  } disp_state_e;

  typedef logic [FITNESS_WIDTH-1:0] fitness_t;

  localparam fitness_t FITNESS_MAX = '1;

endpackage

// File: rtl/fitness_adder_tree.sv
// Three-level pairwise adder tree; each level grows by one bit so the
// 8 x 32-bit sum can never wrap in the 35-bit result.
module fitness_adder_tree
  import dispatcher_pkg::*;
(
  input  logic [NUM_OUTPUTS-1:0][ERR_WIDTH-1:0] terms,
  output logic [FITNESS_WIDTH-1:0]              sum
);

  logic [ERR_WIDTH:0]   lvl1 [4];
  logic [ERR_WIDTH+1:0] lvl2 [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = {1'b0, terms[2*i]} + {1'b0, terms[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end
    sum = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

endmodule

// File: rtl/evaluation_dispatcher.sv
// Hands one chromosome at a time to the fitness processor, sums its error
// outputs and tracks the best fitness. Optional watchdog: DISPATCHER_TIMEOUT_EN.
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | waiting for an evaluation request
// WAIT_READY  | chromosome latched, waiting for processor idle
// START       | one-cycle start pulse to the processor
// WAIT_DONE   | processor running, waiting for its done state
// ACK         | one-cycle done feedback, error sums captured
// SUM         | fitness registered from the adder tree
// RESULT      | result valid, waiting for downstream ack
module evaluation_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                                  iClock,
  input  logic                                  iReset,
  input  logic                                  iEvalRequest,
  input  logic [7:0]                            iChromId,
  input  logic [CHROM_WIDTH-1:0]                iChromosome,
  output logic                                  oBusy,
  output logic [CHROM_WIDTH-1:0]                oConcatedChromDescription,
  output logic                                  oStartProcessing,
  input  logic                                  iReadyToProcess,
  input  logic                                  iDoneProcessing,
  output logic                                  oDoneProcessingFeedback,
  input  logic                                  iPause,
  output logic                                  oStall,
  input  logic [NUM_OUTPUTS-1:0][ERR_WIDTH-1:0] iErrorSums,
  output logic                                  oResultValid,
  input  logic                                  iResultAck,
  output logic [FITNESS_WIDTH-1:0]              oFitness,
  output logic [7:0]                            oResultId,
  output logic                                  oTimeout,
  input  logic                                  iClearBest,
  output logic [FITNESS_WIDTH-1:0]              oBestFitness,
  output logic [7:0]                            oBestId
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  disp_state_e                          state_q, state_d;
  logic [CHROM_WIDTH-1:0]               chrom_q, chrom_d;
  logic [7:0]                           id_q, id_d;
  logic [NUM_OUTPUTS-1:0][ERR_WIDTH-1:0] err_q, err_d;
  fitness_t                             fitness_q, fitness_d;
  logic [7:0]                           result_id_q, result_id_d;
  logic                                 valid_q, valid_d;
  logic                                 timeout_q, timeout_d;
  fitness_t                             best_fit_q, best_fit_d;
  logic [7:0]                           best_id_q, best_id_d;
  logic                                 stall_q, stall_d;

  fitness_t sum;
  logic     wd_expired;
  logic     timeout_hit;

  fitness_adder_tree u_adder (
    .terms (err_q),
    .sum   (sum)
  );

`ifdef DISPATCHER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait;

  assign in_wait    = (state_q == ST_WAIT_READY) || (state_q == ST_WAIT_DONE);
  assign wd_expired = in_wait && !stall_q && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Count only while sitting in a wait state; any state change clears it.
  always_comb begin
    wd_d = '0;
    if (in_wait && (state_d == state_q)) begin
      wd_d = stall_q ? wd_q : wd_q + 1'b1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Real progress wins over a watchdog expiry landing on the same cycle.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE:       if (iEvalRequest) state_d = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (iReadyToProcess) begin
          state_d = ST_START;
        end else if (wd_expired) begin
          state_d     = ST_RESULT;
          timeout_hit = 1'b1;
        end
      end
      ST_START:      state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (iDoneProcessing) begin
          state_d = ST_ACK;
        end else if (wd_expired) begin
          state_d     = ST_RESULT;
          timeout_hit = 1'b1;
        end
      end
      ST_ACK:        state_d = ST_SUM;
      ST_SUM:        state_d = ST_RESULT;
      ST_RESULT:     if (iResultAck) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    chrom_d     = chrom_q;
    id_d        = id_q;
    err_d       = err_q;
    fitness_d   = fitness_q;
    result_id_d = result_id_q;
    timeout_d   = timeout_q;
    best_fit_d  = best_fit_q;
    best_id_d   = best_id_q;
    valid_d     = (state_d == ST_RESULT);
    stall_d     = iPause;

    if ((state_q == ST_IDLE) && iEvalRequest) begin
      chrom_d = iChromosome;
      id_d    = iChromId;
    end

    if ((state_q == ST_WAIT_DONE) && iDoneProcessing) begin
      err_d = iErrorSums;
    end

    if (state_q == ST_SUM) begin
      fitness_d   = sum;
      result_id_d = id_q;
      timeout_d   = 1'b0;
      if (sum < best_fit_q) begin
        best_fit_d = sum;
        best_id_d  = id_q;
      end
    end

    if (timeout_hit) begin
      fitness_d   = FITNESS_MAX;
      result_id_d = id_q;
      timeout_d   = 1'b1;
    end

    if (iClearBest) begin
      best_fit_d = FITNESS_MAX;
      best_id_d  = '0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      chrom_q     <= '0;
      id_q        <= '0;
      err_q       <= '0;
      fitness_q   <= '0;
      result_id_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      best_fit_q  <= FITNESS_MAX;
      best_id_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      chrom_q     <= chrom_d;
      id_q        <= id_d;
      err_q       <= err_d;
      fitness_q   <= fitness_d;
      result_id_q <= result_id_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      best_fit_q  <= best_fit_d;
      best_id_q   <= best_id_d;
      stall_q     <= stall_d;
    end
  end

  assign oBusy                     = (state_q != ST_IDLE);
  assign oStartProcessing          = (state_q == ST_START);
  assign oDoneProcessingFeedback   = (state_q == ST_ACK);
  assign oConcatedChromDescription = chrom_q;
  assign oStall                    = stall_q;
  assign oResultValid              = valid_q;
  assign oFitness                  = fitness_q;
  assign oResultId                 = result_id_q;
  assign oTimeout                  = timeout_q;
  assign oBestFitness              = best_fit_q;
  assign oBestId                   = best_id_q;

endmodule

// File: doc/evaluation_dispatcher.md
EVALUATION_DISPATCHER -- requirements
Module: evaluation_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536, watchdog limit in clock cycles (used only with DISPATCHER_TIMEOUT_EN).
REQ-002 SHALL have port iClock  in  1  single clock; all logic on posedge.
REQ-003 SHALL have port iReset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port iEvalRequest  in  1  upstream request to evaluate one chromosome.
REQ-005 SHALL have port iChromId  in  8  upstream chromosome identifier.
REQ-006 SHALL have port iChromosome  in  992  upstream chromosome description.
REQ-007 SHALL have port oBusy  out  1  high whenever state is not IDLE.
REQ-008 SHALL have port oConcatedChromDescription  out  992  latched description to the processor.
REQ-009 SHALL have port oStartProcessing  out  1  start pulse to the processor.
REQ-010 SHALL have port iReadyToProcess  in  1  processor is idle.
REQ-011 SHALL have port iDoneProcessing  in  1  processor is in its done state.
REQ-012 SHALL have port oDoneProcessingFeedback  out  1  done acknowledge pulse to the processor.
REQ-013 SHALL have port iPause  in  1  request to hold the processor at end of run.
REQ-014 SHALL have port oStall  out  1  registered iPause, drives the processor stall input.
REQ-015 SHALL have port iErrorSums  in  8x32  per-output error sums from the processor.
REQ-016 SHALL have port oResultValid  out  1  result available.
REQ-017 SHALL have port iResultAck  in  1  downstream consumes result.
REQ-018 SHALL have port oFitness  out  35  sum of the 8 error sums for the last run.
REQ-019 SHALL have port oResultId  out  8  iChromId of the last run.
REQ-020 SHALL have port oTimeout  out  1  last result ended by watchdog.
REQ-021 SHALL have port iClearBest  in  1  reset best-so-far tracking.
REQ-022 SHALL have ports oBestFitness  out  35 and oBestId  out  8, lowest fitness seen and its id.

Function
REQ-023 SHALL implement states IDLE, WAIT_READY, START, WAIT_DONE, ACK, SUM, RESULT.
REQ-024 SHALL, in IDLE on iEvalRequest, latch iChromosome and iChromId and go to WAIT_READY; requests while oBusy=1 SHALL be ignored, not queued.
REQ-025 SHALL hold oConcatedChromDescription constant from latch until return to IDLE.
REQ-026 SHALL go WAIT_READY->START when iReadyToProcess=1; START SHALL assert oStartProcessing for exactly one cycle and go to WAIT_DONE.
REQ-027 SHALL, in WAIT_DONE with iDoneProcessing=1, capture iErrorSums and go to ACK; ACK SHALL assert oDoneProcessingFeedback for exactly one cycle and go to SUM.
REQ-028 SHALL, in SUM, register oFitness = zero-extended sum of the 8 captured values (35 bits, no overflow) and go to RESULT; oResultValid SHALL rise the cycle after SUM.
REQ-029 SHALL hold oResultValid, oFitness, oResultId stable in RESULT until iResultAck=1, then go to IDLE; oResultValid SHALL deassert the following cycle.
REQ-030 SHALL, on SUM->RESULT, load oBestFitness/oBestId if fitness is strictly less than oBestFitness; ties keep the earlier id.
REQ-031 SHALL give iClearBest priority over a simultaneous best update, setting oBestFitness to all ones and oBestId to 0.
REQ-032 SHALL register oStall from iPause with one cycle latency in every state.

Reset
REQ-033 SHALL, on iReset at any state including mid-run, go to IDLE with all pulse/valid outputs, oStall, oTimeout, oFitness, oResultId, oBestId, watchdog count and latched description 0, and oBestFitness all ones.

Configuration
REQ-034 SHALL, with DISPATCHER_TIMEOUT_EN defined, count cycles in WAIT_READY/WAIT_DONE (count frozen while oStall=1, cleared on leaving them) and at TIMEOUT_CYCLES go directly to RESULT with oTimeout=1, oFitness all ones, best untouched; without it, no counter exists and oTimeout is tied 0.

Structure
REQ-035 SHALL take state enum, CHROM_WIDTH=992, NUM_OUTPUTS=8, ERR_WIDTH=32, FITNESS_WIDTH=35 from shared package dispatcher_pkg.
REQ-036 SHALL place the 8-input summation in sub-module fitness_adder_tree.

Verification
REQ-037 SHALL cover: request id=0x05, ready=1, done after 40 cycles with sums {1,2,3,4,5,6,7,8} -> one-cycle start, one-cycle feedback, oFitness=36, oResultId=0x05, best=36/0x05.
REQ-038 SHALL cover: all sums 0xFFFFFFFF -> oFitness=0x7FFFFFFF8, no wrap.
REQ-039 SHALL cover: runs with fitness 20 (id 1), 20 (id 2), 10 (id 3) -> best 20/1 then 10/3; iClearBest with third update same cycle -> best all ones/0.
REQ-040 SHALL cover: iEvalRequest while busy -> ignored, id unchanged; iReset in WAIT_DONE -> IDLE next cycle, all outputs at reset values.
REQ-041 SHALL cover: DISPATCHER_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> RESULT after 16 cycles, oTimeout=1, oFitness all ones; iPause=1 -> oStall=1 next cycle, timeout delayed.
